// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared types and constants for the sequential picoMIPS decoder.
//   - opcode values (as int localparams so any OPCODE_W can cast them)
//   - opcode_e  : opcode enum at the default 3-bit width
//   - dec_state_t : decoder FSM states
// Build option: DECODER_TRAP_EN adds the HALT state.
// ---------------------------------------------------------------------------
package decoder_pkg;

   localparam int OPCODE_W_DEF = 3;

   localparam int OP_ACCI = 0;
   localparam int OP_MACI = 1;
   localparam int OP_BEQ  = 2;
   localparam int OP_BNE  = 3;
   localparam int OP_NOP  = 4;

   typedef enum logic [OPCODE_W_DEF-1:0] {
      OPC_ACCI = OPCODE_W_DEF'(OP_ACCI),
      OPC_MACI = OPCODE_W_DEF'(OP_MACI),
      OPC_BEQ  = OPCODE_W_DEF'(OP_BEQ),
      OPC_BNE  = OPCODE_W_DEF'(OP_BNE),
      OPC_NOP  = OPCODE_W_DEF'(OP_NOP)
   } opcode_e;

   // WAIT_IN and MAC_BUSY each belong to exactly one instruction, so the
   // state itself records which instruction is pending.
   typedef enum logic [1:0] {
      S_EXEC     = 2'd0,
      S_WAIT_IN  = 2'd1,
      S_MAC_BUSY = 2'd2
`ifdef DECODER_TRAP_EN
      , S_HALT   = 2'd3
`endif
   } dec_state_t;

endpackage

// File: rtl/busy_counter.sv
// ---------------------------------------------------------------------------
// busy_counter
// Loadable down-counter with a terminal flag, used to time the MAC stall.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (count -> 0)
//   load         : load load_val this cycle (has priority over dec)
//   load_val     : value to load
//   dec          : decrement by one (saturates at zero)
//   at_one       : count currently equals 1 (last stall cycle)
// ---------------------------------------------------------------------------
module busy_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         at_one
);

   logic [W-1:0] cnt_d;
   logic [W-1:0] cnt_q;

   // Next count: load wins, otherwise count down and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_one = (cnt_q == W'(1));

endmodule

// File: rtl/decoder_seq.sv
// ---------------------------------------------------------------------------
// decoder_seq
// Sequential picoMIPS instruction decoder: multi-cycle MACI that stalls the
// PC, and a valid/ack handshake on the switch input. Outputs are Mealy
// functions of the FSM state and current inputs.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   opcode, z           : current instruction opcode, ALU zero flag
//   in_valid / in_ack   : switch input handshake (ack is a 1-cycle pulse)
//   acc_en, acc_add,
//   in_en, w            : accumulator / register-file control
//   pc_incr,
//   pc_relbranch        : program counter control
//   busy                : FSM is outside EXEC
//   illegal             : sticky trap flag (DECODER_TRAP_EN builds only)
// Build option: DECODER_TRAP_EN -- illegal opcodes trap into HALT;
// otherwise they execute as NOP.
// ---------------------------------------------------------------------------
module decoder_seq
   import decoder_pkg::*;
#(
   parameter int OPCODE_W   = 3,
   parameter int MAC_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                z,
   input  logic                in_valid,
   output logic                in_ack,
   output logic                acc_en,
   output logic                acc_add,
   output logic                in_en,
   output logic                w,
   output logic                pc_incr,
   output logic                pc_relbranch,
   output logic                busy
`ifdef DECODER_TRAP_EN
   ,
   output logic                illegal
`endif
);

   localparam int CNT_W = $clog2(MAC_CYCLES + 1);

   localparam logic [OPCODE_W-1:0] C_ACCI = OPCODE_W'(OP_ACCI);
   localparam logic [OPCODE_W-1:0] C_MACI = OPCODE_W'(OP_MACI);
   localparam logic [OPCODE_W-1:0] C_BEQ  = OPCODE_W'(OP_BEQ);
   localparam logic [OPCODE_W-1:0] C_BNE  = OPCODE_W'(OP_BNE);
   localparam logic [OPCODE_W-1:0] C_NOP  = OPCODE_W'(OP_NOP);

   // The decode cycle counts as the first MAC cycle, so the stall counter
   // only covers the remaining MAC_CYCLES-1 cycles.
   localparam logic [CNT_W-1:0] MAC_LOAD = CNT_W'(MAC_CYCLES - 1);

   dec_state_t state_d;
   dec_state_t state_q;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_at_one;

   busy_counter #(
      .W (CNT_W)
   ) u_busy_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (MAC_LOAD),
      .dec      (cnt_dec),
      .at_one   (cnt_at_one)
   );

   // Next state and Mealy outputs. Reset gates everything to zero so no
   // half-finished sequence can emit a w or in_ack pulse.
   always_comb begin
      state_d      = state_q;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      in_ack       = 1'b0;
      acc_en       = 1'b0;
      acc_add      = 1'b0;
      in_en        = 1'b0;
      w            = 1'b0;
      pc_incr      = 1'b0;
      pc_relbranch = 1'b0;
      busy         = 1'b0;
`ifdef DECODER_TRAP_EN
      illegal      = 1'b0;
`endif
      if (!reset) begin
         case (state_q)
            S_EXEC: begin
               pc_incr = 1'b1;
               if (opcode == C_ACCI) begin
                  if (in_valid) begin
                     acc_en = 1'b1;
                     in_en  = 1'b1;
                     w      = 1'b1;
                     in_ack = 1'b1;
                  end else begin
                     pc_incr = 1'b0;
                     state_d = S_WAIT_IN;
                  end
               end else if (opcode == C_MACI) begin
                  if (MAC_CYCLES == 1) begin
                     acc_en  = 1'b1;
                     acc_add = 1'b1;
                     w       = 1'b1;
                  end else begin
                     pc_incr  = 1'b0;
                     cnt_load = 1'b1;
                     state_d  = S_MAC_BUSY;
                  end
               end else if (opcode == C_BEQ) begin
                  if (z) begin
                     pc_incr      = 1'b0;
                     pc_relbranch = 1'b1;
                  end
               end else if (opcode == C_BNE) begin
                  if (!z) begin
                     pc_incr      = 1'b0;
                     pc_relbranch = 1'b1;
                  end
               end else if (opcode != C_NOP) begin
`ifdef DECODER_TRAP_EN
                  state_d = S_HALT;
`endif
               end
            end
            S_WAIT_IN: begin
               busy = 1'b1;
               if (in_valid) begin
                  acc_en  = 1'b1;
                  in_en   = 1'b1;
                  w       = 1'b1;
                  in_ack  = 1'b1;
                  pc_incr = 1'b1;
                  state_d = S_EXEC;
               end
            end
            S_MAC_BUSY: begin
               busy    = 1'b1;
               cnt_dec = 1'b1;
               if (cnt_at_one) begin
                  acc_en  = 1'b1;
                  acc_add = 1'b1;
                  w       = 1'b1;
                  pc_incr = 1'b1;
                  state_d = S_EXEC;
               end
            end
`ifdef DECODER_TRAP_EN
            S_HALT: begin
               busy    = 1'b1;
               illegal = 1'b1;
            end
`endif
            default: begin
               state_d = S_EXEC;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_EXEC;
      end else begin
         state_q <= state_d;
      end
   end

endmodule
